// File: rtl/uart_pkg.sv
// Shared constants and baud-FSM state type for the UART receive-side control slice.
package uart_pkg;

  localparam int               BAUD_W       = 13;
  localparam int               DATA_W       = 8;
  localparam logic [BAUD_W-1:0] DEFAULT_BAUD = 13'd5207;

  typedef enum logic {
    IDLE_APPLY = 1'b0,
    WAIT_IDLE  = 1'b1
  } baud_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous receive FIFO with registered read port and registered occupancy flags.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  SCLK,
  input  logic                  RST_n,
  input  logic                  wr_en_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic                  rd_valid_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  rd_accept_o,
  output logic                  drop_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, full_q;
  logic [DATA_W-1:0]     rd_data_q;
  logic                  rd_valid_q;
  logic                  wr_acc, rd_acc;

  // A pop frees a slot in the same cycle, so a write into a full FIFO is accepted alongside it.
  always_comb begin
    rd_acc  = rd_en_i && !empty_q;
    wr_acc  = wr_en_i && (!full_q || rd_acc);
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; only pointers and flags define what is valid.
  always_ff @(posedge SCLK) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge SCLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      rd_valid_q <= rd_acc;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == (DEPTH_LOG2+1)'(DEPTH));
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign count_o     = count_q;
  assign empty_o     = empty_q;
  assign full_o      = full_q;
  assign rd_accept_o = rd_acc;
  assign drop_o      = wr_en_i && full_q && !rd_acc;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: between-frame baud divisor updates, receive FIFO,
// sticky overflow and idle-timeout interrupt.
module uart_rx_ctrl #(
  parameter int          DEPTH_LOG2   = 4,
  parameter logic [12:0] DEFAULT_BAUD = uart_pkg::DEFAULT_BAUD,
  parameter int          TIMEOUT_BITS = 40
) (
  input  logic                          SCLK,
  input  logic                          RST_n,
  input  logic                          cfg_baud_wr,
  input  logic [uart_pkg::BAUD_W-1:0]   cfg_baud_data,
  output logic [uart_pkg::BAUD_W-1:0]   baud_div,
  output logic                          baud_pending,
  input  logic                          rx_done,
  input  logic [uart_pkg::DATA_W-1:0]   rx_data,
  input  logic                          rx_busy,
  input  logic                          rd_en,
  output logic [uart_pkg::DATA_W-1:0]   rd_data,
  output logic                          rd_valid,
  output logic [DEPTH_LOG2:0]           fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          timeout_irq
);

  import uart_pkg::*;

  localparam int TICK_W = $clog2(TIMEOUT_BITS + 1);

  baud_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d, shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              ovf_q, ovf_d;
  logic [BAUD_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              irq_q, irq_d;
  logic              rd_acc, drop, tick, cnt_clr;

  uart_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .SCLK        (SCLK),
    .RST_n       (RST_n),
    .wr_en_i     (rx_done),
    .wr_data_i   (rx_data),
    .rd_en_i     (rd_en),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .rd_accept_o (rd_acc),
    .drop_o      (drop)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    case (state_q)
      IDLE_APPLY: begin
        if (cfg_baud_wr) begin
          if (!rx_busy) begin
            baud_d = cfg_baud_data;
          end else begin
            shadow_d  = cfg_baud_data;
            pending_d = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (cfg_baud_wr) shadow_d = cfg_baud_data;
        if (!rx_busy) begin
          baud_d    = cfg_baud_wr ? cfg_baud_data : shadow_q;
          pending_d = 1'b0;
          state_d   = IDLE_APPLY;
        end
      end
      default: state_d = IDLE_APPLY;
    endcase
  end

  // Idle timer only runs while bytes sit unread and the line is quiet.
  always_comb begin
    ovf_d      = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    tick       = (bit_cnt_q >= baud_q);
    cnt_clr    = rx_done || rx_busy || fifo_empty || rd_acc;
    bit_cnt_d  = bit_cnt_q + 1'b1;
    tick_cnt_d = tick_cnt_q;
    if (cnt_clr) begin
      bit_cnt_d  = '0;
      tick_cnt_d = '0;
    end else if (tick) begin
      bit_cnt_d = '0;
      if (tick_cnt_q != TICK_W'(TIMEOUT_BITS)) tick_cnt_d = tick_cnt_q + 1'b1;
    end
    irq_d = irq_q;
    if (rd_acc || rx_done)                        irq_d = 1'b0;
    else if (tick_cnt_d == TICK_W'(TIMEOUT_BITS)) irq_d = 1'b1;
  end

  always_ff @(posedge SCLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= IDLE_APPLY;
      baud_q     <= DEFAULT_BAUD;
      shadow_q   <= DEFAULT_BAUD;
      pending_q  <= 1'b0;
      ovf_q      <= 1'b0;
      bit_cnt_q  <= '0;
      tick_cnt_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      bit_cnt_q  <= bit_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      irq_q      <= irq_d;
    end
  end

  assign baud_div     = baud_q;
  assign baud_pending = pending_q;
  assign overflow     = ovf_q;
  assign timeout_irq  = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed vectors, corner sequences and a
// randomized run against a queue-based reference model.
module tb_uart_rx_ctrl;

  logic        SCLK = 1'b0;
  logic        RST_n;
  logic        cfg_baud_wr;
  logic [12:0] cfg_baud_data;
  logic [12:0] baud_div;
  logic        baud_pending;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        rx_busy;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;
  logic        ovf_clr;
  logic        timeout_irq;

  int tests_run = 0;
  int tests_failed = 0;

  uart_rx_ctrl dut (
    .SCLK          (SCLK),
    .RST_n         (RST_n),
    .cfg_baud_wr   (cfg_baud_wr),
    .cfg_baud_data (cfg_baud_data),
    .baud_div      (baud_div),
    .baud_pending  (baud_pending),
    .rx_done       (rx_done),
    .rx_data       (rx_data),
    .rx_busy       (rx_busy),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .fifo_count    (fifo_count),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr),
    .timeout_irq   (timeout_irq)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       rd;
    logic [4:0] exp_count;
    logic       exp_valid;
    logic [7:0] exp_rdata;
    logic       exp_empty;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge SCLK);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_baud_wr   = 1'b0;
    cfg_baud_data = '0;
    rx_done       = 1'b0;
    rx_data       = '0;
    rx_busy       = 1'b0;
    rd_en         = 1'b0;
    ovf_clr       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_n = 1'b0;
    repeat (2) @(negedge SCLK);
    RST_n = 1'b1;
    #1;
  endtask

  // Reference model state
  byte unsigned model_q[$];
  logic [12:0]  m_baud, m_shadow;
  logic         m_pend, m_ovf, m_valid;
  logic [7:0]   m_rdata;

  initial begin
    int n;
    do_reset();

    // Reset state
    check("rst_baud", baud_div, 13'd5207);
    check("rst_pending", baud_pending, 0);
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_irq", timeout_irq, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_rdata", rd_data, 0);

    // Baud change while idle, then while busy
    cfg_baud_wr = 1; cfg_baud_data = 13'd433;
    step();
    cfg_baud_wr = 0;
    check("baud_idle_apply", baud_div, 13'd433);
    check("baud_idle_pending", baud_pending, 0);
    rx_busy = 1; cfg_baud_wr = 1; cfg_baud_data = 13'd1000;
    step();
    cfg_baud_wr = 0;
    check("baud_busy_pending", baud_pending, 1);
    check("baud_busy_hold", baud_div, 13'd433);
    cfg_baud_wr = 1; cfg_baud_data = 13'd1234;
    step();
    cfg_baud_wr = 0;
    repeat (3) step();
    check("baud_busy_hold2", baud_div, 13'd433);
    rx_busy = 0;
    step();
    check("baud_applied", baud_div, 13'd1234);
    check("baud_pending_clr", baud_pending, 0);

    // Table-driven FIFO vectors
    do_reset();
    vecs[0] = '{1, 8'h55, 0, 5'd1, 0, 8'h00, 0};
    vecs[1] = '{1, 8'hA3, 0, 5'd2, 0, 8'h00, 0};
    vecs[2] = '{1, 8'h0F, 0, 5'd3, 0, 8'h00, 0};
    vecs[3] = '{0, 8'h00, 1, 5'd2, 1, 8'h55, 0};
    vecs[4] = '{0, 8'h00, 1, 5'd1, 1, 8'hA3, 0};
    vecs[5] = '{0, 8'h00, 1, 5'd0, 1, 8'h0F, 1};
    vecs[6] = '{0, 8'h00, 1, 5'd0, 0, 8'h0F, 1};
    vecs[7] = '{1, 8'h99, 1, 5'd1, 0, 8'h0F, 0};
    vecs[8] = '{1, 8'h3C, 1, 5'd1, 1, 8'h99, 0};
    vecs[9] = '{0, 8'h00, 1, 5'd0, 1, 8'h3C, 1};
    for (int i = 0; i < 10; i++) begin
      rx_done = vecs[i].done; rx_data = vecs[i].data; rd_en = vecs[i].rd;
      step();
      check($sformatf("vec%0d_count", i), fifo_count, vecs[i].exp_count);
      check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_rdata", i), rd_data, vecs[i].exp_rdata);
      check($sformatf("vec%0d_empty", i), fifo_empty, vecs[i].exp_empty);
    end
    idle_inputs();

    // Fill to full, overflow on the 17th byte
    do_reset();
    for (int i = 0; i < 17; i++) begin
      rx_done = 1; rx_data = 8'(i + 1);
      step();
      if (i == 15) begin
        check("fill_full", fifo_full, 1);
        check("fill_no_ovf", overflow, 0);
      end
    end
    rx_done = 0;
    check("ovf_count", fifo_count, 16);
    check("ovf_set", overflow, 1);
    rx_done = 1; rx_data = 8'hEE; rd_en = 1;
    step();
    rx_done = 0; rd_en = 0;
    check("full_pushpop_count", fifo_count, 16);
    check("full_pushpop_valid", rd_valid, 1);
    check("full_pushpop_data", rd_data, 8'h01);
    check("full_pushpop_ovf", overflow, 1);
    rx_done = 1; ovf_clr = 1;
    step();
    rx_done = 0;
    check("ovf_set_wins", overflow, 1);
    step();
    ovf_clr = 0;
    check("ovf_cleared", overflow, 0);
    check("ovf_clr_count", fifo_count, 16);

    // Idle timeout with divisor 9 (10 cycles per bit, 40 bits)
    do_reset();
    cfg_baud_wr = 1; cfg_baud_data = 13'd9;
    step();
    cfg_baud_wr = 0;
    rx_done = 1; rx_data = 8'h42;
    step();
    rx_done = 0;
    n = 0;
    while (!timeout_irq && n < 600) begin
      step();
      n++;
    end
    check("timeout_latency_ok", (n >= 399 && n <= 401), 1);
    check("timeout_irq_high", timeout_irq, 1);
    rd_en = 1;
    step();
    rd_en = 0;
    check("timeout_irq_clr", timeout_irq, 0);
    check("timeout_pop_data", rd_data, 8'h42);

    // Asynchronous reset while waiting to apply a divisor, FIFO non-empty
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rx_done = 1; rx_data = 8'(8'hA0 + i);
      step();
    end
    rx_done = 0;
    rx_busy = 1; cfg_baud_wr = 1; cfg_baud_data = 13'd77;
    step();
    cfg_baud_wr = 0;
    check("wait_pending", baud_pending, 1);
    check("wait_count", fifo_count, 5);
    #2 RST_n = 1'b0;
    #1;
    check("areset_baud", baud_div, 13'd5207);
    check("areset_count", fifo_count, 0);
    check("areset_pending", baud_pending, 0);
    check("areset_empty", fifo_empty, 1);
    @(negedge SCLK);
    RST_n = 1'b1;
    rx_busy = 0;
    step();
    check("areset_discarded", baud_div, 13'd5207);

    // Randomized run against the reference model
    do_reset();
    model_q.delete();
    m_baud = 13'd5207; m_shadow = 13'd5207; m_pend = 0; m_ovf = 0; m_valid = 0; m_rdata = 0;
    for (int c = 0; c < 1500; c++) begin
      bit full_pre, pop;
      rx_done = ($urandom_range(0, 99) < 40);
      rx_data = 8'($urandom);
      rd_en   = ($urandom_range(0, 99) < 30);
      ovf_clr = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 20) rx_busy = ~rx_busy;
      cfg_baud_wr   = ($urandom_range(0, 99) < 5) && !(m_pend && !rx_busy);
      cfg_baud_data = 13'(200 + $urandom_range(0, 7900));

      full_pre = (model_q.size() == 16);
      pop = rd_en && (model_q.size() != 0);
      m_valid = pop;
      if (pop) m_rdata = model_q.pop_front();
      if (rx_done) begin
        if (!full_pre || pop) model_q.push_back(rx_data);
      end
      if (rx_done && full_pre && !pop) m_ovf = 1;
      else if (ovf_clr)                m_ovf = 0;
      if (m_pend) begin
        if (cfg_baud_wr) m_shadow = cfg_baud_data;
        if (!rx_busy) begin m_baud = m_shadow; m_pend = 0; end
      end else if (cfg_baud_wr) begin
        if (!rx_busy) m_baud = cfg_baud_data;
        else begin m_shadow = cfg_baud_data; m_pend = 1; end
      end

      step();
      check("rnd_count", fifo_count, model_q.size());
      check("rnd_empty", fifo_empty, model_q.size() == 0);
      check("rnd_full", fifo_full, model_q.size() == 16);
      check("rnd_valid", rd_valid, m_valid);
      check("rnd_rdata", rd_data, m_rdata);
      check("rnd_ovf", overflow, m_ovf);
      check("rnd_baud", baud_div, m_baud);
      check("rnd_pending", baud_pending, m_pend);
      check("rnd_irq", timeout_irq, 0);
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
